// File: rtl/fmap_pkg.sv
// Shared feature-map SRAM definitions, used by both the read-side and the
// write-side address controllers.
//   - top_state_e  : encoding of the top controller FSM state bus
//   - wr_state_e   : write-side controller states
//   - bank_t       : parity-interleaved bank index {row[0], col[0]}
//   - FMAP_*       : default pixel width, row-pair pitch and border offset
//   - calc_waddr / calc_bank / is_layer_state : address map helpers
package fmap_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PADDING = 4'd1,
        ST_CONV1   = 4'd2,
        ST_RES_1   = 4'd3,
        ST_RES_2   = 4'd4,
        ST_UP_1    = 4'd5,
        ST_UP_2    = 4'd6,
        ST_CONV2   = 4'd7,
        ST_FINISH  = 4'd8
    } top_state_e;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACTIVE = 2'd1,
        W_DONE   = 2'd2
    } wr_state_e;

    typedef logic [1:0] bank_t;

    localparam int FMAP_DATA_W         = 96;
    localparam int FMAP_ROW_PAIR_WORDS = 321;
    localparam int FMAP_PAD            = 1;

    // Word address inside a bank: each bank holds one pixel of every 2x2 block.
    function automatic logic [15:0] calc_waddr(input logic [8:0] row,
                                               input logic [9:0] col,
                                               input int         rpw);
        logic [31:0] full;
        full = 32'(col >> 1) + 32'(row >> 1) * $unsigned(rpw);
        return full[15:0];
    endfunction

    function automatic bank_t calc_bank(input logic row0, input logic col0);
        return {row0, col0};
    endfunction

    // Layers that produce result pixels (CONV1 .. CONV2).
    function automatic logic is_layer_state(input logic [3:0] s);
        return (s >= 4'd2) && (s <= 4'd7);
    endfunction

endpackage

// File: rtl/fmap_pos_counter.sv
// Output pixel position tracker (row, col) for one layer.
//   clk, rst_n        : clock, async active-low reset
//   restart           : latch frame_w/frame_h and return to (PAD, PAD)
//   adv               : advance one pixel in raster order
//   frame_w, frame_h  : interior frame size for the layer being started
//   row, col          : current pixel position
//   last              : current position is the final pixel of the frame
module fmap_pos_counter
    import fmap_pkg::*;
#(
    parameter int PAD = FMAP_PAD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       adv,
    input  logic [9:0] frame_w,
    input  logic [8:0] frame_h,
    output logic [8:0] row,
    output logic [9:0] col,
    output logic       last
);

    logic [9:0] fw_q, fw_d;
    logic [8:0] fh_q, fh_d;
    logic [8:0] row_q, row_d;
    logic [9:0] col_q, col_d;
    logic       last_col, last_row;

    // Compare one bit wider so frame + PAD never wraps.
    assign last_col = ({1'b0, col_q} == ({1'b0, fw_q} + 11'(PAD) - 11'd1));
    assign last_row = ({1'b0, row_q} == ({1'b0, fh_q} + 10'(PAD) - 10'd1));

    always_comb begin
        fw_d  = fw_q;
        fh_d  = fh_q;
        row_d = row_q;
        col_d = col_q;
        if (restart) begin
            fw_d  = frame_w;
            fh_d  = frame_h;
            row_d = 9'(PAD);
            col_d = 10'(PAD);
        end else if (adv) begin
            if (last_col) begin
                col_d = 10'(PAD);
                row_d = row_q + 9'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_q  <= 10'd1;
            fh_q  <= 9'd1;
            row_q <= 9'(PAD);
            col_q <= 10'(PAD);
        end else begin
            fw_q  <= fw_d;
            fh_q  <= fh_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = last_col && last_row;

endmodule

// File: rtl/sram_write_addr_ctl.sv
// Feature-map SRAM write address controller. Writes the result stream into
// the four parity-interleaved banks of SRAM_A or SRAM_B and ping-pongs the
// destination array per layer.
//   clk, rst_n            : clock, async active-low reset
//   state                 : top controller FSM state
//   layer_start           : arms a new layer (latches frame_w/frame_h)
//   frame_w, frame_h      : interior frame size
//   in_valid, in_data     : result pixel stream
//   sram_wen_a/_b         : active-low bank write enables (one low at most)
//   sram_waddr/_wdata     : shared write address / data
//   layer_done            : pulses with the final write of a layer
//   dest_b                : 1 = current layer targets SRAM_B
//   err_overflow          : sticky misuse flag, built only when
//                           WADDR_OVF_CHECK_EN is defined (else tied 0)
//
// state    | meaning
// W_IDLE   | waiting for layer_start in a result-producing top state
// W_ACTIVE | accepting pixels, one write per in_valid beat
// W_DONE   | final write on the bus; flip destination array on exit
module sram_write_addr_ctl
    import fmap_pkg::*;
#(
    parameter int DATA_W         = FMAP_DATA_W,
    parameter int ROW_PAIR_WORDS = FMAP_ROW_PAIR_WORDS,
    parameter int PAD            = FMAP_PAD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        state,
    input  logic              layer_start,
    input  logic [9:0]        frame_w,
    input  logic [8:0]        frame_h,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        sram_wen_a,
    output logic [3:0]        sram_wen_b,
    output logic [15:0]       sram_waddr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              layer_done,
    output logic              dest_b,
    output logic              err_overflow
);

    wr_state_e          st_q, st_d;
    logic               dest_b_q, dest_b_d;
    logic [3:0]         wen_a_q, wen_a_d;
    logic [3:0]         wen_b_q, wen_b_d;
    logic [15:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               done_q, done_d;

    logic               restart, adv, write;
    logic               kill;
    logic [8:0]         row;
    logic [9:0]         col;
    logic               last;
    bank_t              cur_bank;
    logic [3:0]         cur_wen;

    fmap_pos_counter #(
        .PAD (PAD)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .adv     (adv),
        .frame_w (frame_w),
        .frame_h (frame_h),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    assign kill     = (state == ST_IDLE) || (state == ST_FINISH);
    assign cur_bank = calc_bank(row[0], col[0]);
    assign cur_wen  = ~(4'b0001 << cur_bank);

    always_comb begin
        st_d     = st_q;
        dest_b_d = dest_b_q;
        wen_a_d  = 4'hF;
        wen_b_d  = 4'hF;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        restart  = 1'b0;
        adv      = 1'b0;
        write    = 1'b0;

        if (kill) begin
            st_d     = W_IDLE;
            dest_b_d = 1'b1;
        end else begin
            case (st_q)
                W_IDLE: begin
                    if (layer_start && is_layer_state(state)) begin
                        restart = 1'b1;
                        st_d    = W_ACTIVE;
                    end
                end
                W_ACTIVE: begin
                    // A restart wins over a coincident beat, which is dropped.
                    if (layer_start) begin
                        restart = 1'b1;
                    end else if (in_valid && (state != ST_PADDING)) begin
                        write = 1'b1;
                        adv   = 1'b1;
                        if (last) begin
                            st_d   = W_DONE;
                            done_d = 1'b1;
                        end
                    end
                end
                W_DONE: begin
                    st_d     = W_IDLE;
                    dest_b_d = ~dest_b_q;
                end
                default: st_d = W_IDLE;
            endcase
        end

        if (write) begin
            if (dest_b_q) wen_b_d = cur_wen;
            else          wen_a_d = cur_wen;
            waddr_d = calc_waddr(row, col, ROW_PAIR_WORDS);
            wdata_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= W_IDLE;
            dest_b_q <= 1'b1;
            wen_a_q  <= 4'hF;
            wen_b_q  <= 4'hF;
            waddr_q  <= 16'd0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            dest_b_q <= dest_b_d;
            wen_a_q  <= wen_a_d;
            wen_b_q  <= wen_b_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
        end
    end

`ifdef WADDR_OVF_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((in_valid && ((st_q == W_IDLE) || (st_q == W_DONE))) ||
                     (layer_start && (st_q == W_ACTIVE))) begin
            err_q <= 1'b1;
        end
    end

    assign err_overflow = err_q;
`else
    assign err_overflow = 1'b0;
`endif

    assign sram_wen_a = wen_a_q;
    assign sram_wen_b = wen_b_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;
    assign layer_done = done_q;
    assign dest_b     = dest_b_q;

endmodule

// File: tb/tb_sram_write_addr_ctl.sv
module tb_sram_write_addr_ctl;
    import fmap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  state;
    logic        layer_start;
    logic [9:0]  frame_w;
    logic [8:0]  frame_h;
    logic        in_valid;
    logic [95:0] in_data;
    logic [3:0]  sram_wen_a, sram_wen_b;
    logic [15:0] sram_waddr;
    logic [95:0] sram_wdata;
    logic        layer_done, dest_b, err_overflow;

    int n_checks = 0;
    int n_err    = 0;

    int exp_bank[8] = '{3, 2, 3, 2, 1, 0, 1, 0};
    int exp_addr[8] = '{0, 1, 1, 2, 321, 322, 322, 323};

    logic exp_err;
    int   early_done;
    logic [3:0] ew;

    sram_write_addr_ctl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .layer_start  (layer_start),
        .frame_w      (frame_w),
        .frame_h      (frame_h),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .sram_wen_a   (sram_wen_a),
        .sram_wen_b   (sram_wen_b),
        .sram_waddr   (sram_waddr),
        .sram_wdata   (sram_wdata),
        .layer_done   (layer_done),
        .dest_b       (dest_b),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef WADDR_OVF_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0; state = 4'd0; layer_start = 1'b0;
        frame_w = 10'd0; frame_h = 9'd0; in_valid = 1'b0; in_data = '0;

        // reset values
        tick(); tick();
        chk("rst_wen_a", 96'(sram_wen_a), 96'hF);
        chk("rst_wen_b", 96'(sram_wen_b), 96'hF);
        chk("rst_waddr", 96'(sram_waddr), 96'd0);
        chk("rst_wdata", sram_wdata, 96'd0);
        chk("rst_done", 96'(layer_done), 96'd0);
        chk("rst_dest_b", 96'(dest_b), 96'd1);
        chk("rst_err", 96'(err_overflow), 96'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // layer 1: 4x2 into SRAM_B, continuous valid
        state = 4'd2; frame_w = 10'd4; frame_h = 9'd2; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 96'(32'hA000 + i);
            tick();
            ew = ~(4'b0001 << exp_bank[i]);
            chk("l1_wen_b", 96'(sram_wen_b), 96'(ew));
            chk("l1_wen_a", 96'(sram_wen_a), 96'hF);
            chk("l1_addr", 96'(sram_waddr), 96'(exp_addr[i]));
            chk("l1_data", sram_wdata, 96'(32'hA000 + i));
            chk("l1_done", 96'(layer_done), 96'(i == 7));
        end
        in_valid = 1'b0;
        tick();
        chk("l1_dest_after", 96'(dest_b), 96'd0);
        chk("l1_wen_idle", 96'(sram_wen_b), 96'hF);
        chk("l1_done_clear", 96'(layer_done), 96'd0);

        // layer 2: same size into SRAM_A
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 96'(32'hB000 + i);
            tick();
            ew = ~(4'b0001 << exp_bank[i]);
            chk("l2_wen_a", 96'(sram_wen_a), 96'(ew));
            chk("l2_wen_b", 96'(sram_wen_b), 96'hF);
            chk("l2_addr", 96'(sram_waddr), 96'(exp_addr[i]));
        end
        chk("l2_done", 96'(layer_done), 96'd1);
        in_valid = 1'b0;
        tick();
        chk("l2_dest_after", 96'(dest_b), 96'd1);

        // layer 3: 2x1 with gapped valid, into SRAM_B
        frame_w = 10'd2; frame_h = 9'd1; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        in_valid = 1'b1; in_data = 96'h11;
        tick();
        chk("l3_w0_wen", 96'(sram_wen_b), 96'b0111);
        chk("l3_w0_addr", 96'(sram_waddr), 96'd0);
        chk("l3_w0_done", 96'(layer_done), 96'd0);
        in_valid = 1'b0;
        tick();
        chk("l3_gap_wen", 96'({sram_wen_a, sram_wen_b}), 96'hFF);
        in_valid = 1'b1; in_data = 96'h22;
        tick();
        chk("l3_w1_wen", 96'(sram_wen_b), 96'b1011);
        chk("l3_w1_addr", 96'(sram_waddr), 96'd1);
        chk("l3_w1_data", sram_wdata, 96'h22);
        chk("l3_w1_done", 96'(layer_done), 96'd1);
        in_valid = 1'b0;
        tick();
        chk("l3_gap2_wen", 96'({sram_wen_a, sram_wen_b}), 96'hFF);
        chk("l3_dest_after", 96'(dest_b), 96'd0);

        // layer 4: 4x2 into SRAM_A, restarted after 3 pixels
        frame_w = 10'd4; frame_h = 9'd2; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 96'(i);
            tick();
        end
        chk("l4_third_addr", 96'(sram_waddr), 96'd1);
        layer_start = 1'b1; in_valid = 1'b1; in_data = 96'hDEAD;
        tick();
        layer_start = 1'b0;
        chk("l4_drop_wen", 96'({sram_wen_a, sram_wen_b}), 96'hFF);
        chk("l4_no_done", 96'(layer_done), 96'd0);
        chk("l4_err", 96'(err_overflow), 96'(exp_err));
        in_valid = 1'b1; in_data = 96'h33;
        tick();
        chk("l4_restart_wen", 96'(sram_wen_a), 96'b0111);
        chk("l4_restart_addr", 96'(sram_waddr), 96'd0);
        chk("l4_dest_kept", 96'(dest_b), 96'd0);
        in_valid = 1'b1; in_data = 96'h44;
        tick();
        chk("l4_next_wen", 96'(sram_wen_a), 96'b1011);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wen", 96'({sram_wen_a, sram_wen_b}), 96'hFF);
        chk("arst_dest_b", 96'(dest_b), 96'd1);
        chk("arst_fsm", 96'(dut.st_q), 96'(W_IDLE));
        chk("arst_err", 96'(err_overflow), 96'd0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();

        // wide layer 640x1 into SRAM_B: last pixel (1,640)
        state = 4'd3; frame_w = 10'd640; frame_h = 9'd1; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        early_done = 0;
        for (int i = 0; i < 640; i++) begin
            in_valid = 1'b1; in_data = 96'(i);
            tick();
            if (i < 639 && layer_done) early_done++;
        end
        chk("wide_early_done", 96'(early_done), 96'd0);
        chk("wide_last_wen", 96'(sram_wen_b), 96'b1011);
        chk("wide_last_addr", 96'(sram_waddr), 96'd320);
        chk("wide_last_done", 96'(layer_done), 96'd1);
        in_valid = 1'b0;
        tick();
        chk("wide_dest_after", 96'(dest_b), 96'd0);

        // FINISH mid-layer abandons it and restores dest_b
        state = 4'd5; frame_w = 10'd4; frame_h = 9'd2; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        in_valid = 1'b1;
        tick();
        chk("fin_pre_wen", 96'(sram_wen_a), 96'b0111);
        in_valid = 1'b0; state = 4'd8;
        tick();
        chk("fin_dest_b", 96'(dest_b), 96'd1);
        chk("fin_fsm", 96'(dut.st_q), 96'(W_IDLE));

        // tall layer 2x358 into SRAM_B with a PADDING stall first
        state = 4'd7; frame_w = 10'd2; frame_h = 9'd358; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        state = 4'd1; in_valid = 1'b1;
        tick();
        chk("pad_no_write", 96'({sram_wen_a, sram_wen_b}), 96'hFF);
        state = 4'd7;
        early_done = 0;
        for (int i = 0; i < 716; i++) begin
            in_valid = 1'b1; in_data = 96'(i);
            tick();
            if (i < 715 && layer_done) early_done++;
        end
        chk("tall_early_done", 96'(early_done), 96'd0);
        chk("tall_last_wen", 96'(sram_wen_b), 96'b1110);
        chk("tall_last_addr", 96'(sram_waddr), 96'd57460);
        chk("tall_last_done", 96'(layer_done), 96'd1);
        in_valid = 1'b0;
        tick();
        chk("tall_dest_after", 96'(dest_b), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
